// File: rtl/control_unit_if.sv
// ---------------------------------------------------------------------------
// control_unit_if
// Bundles the instruction/status inputs and all control outputs exchanged
// between the multicycle control unit and its datapath.
//   master : control unit side (receives instr/zero/mem_ready, drives controls)
//   slave  : datapath side (drives instr/zero/mem_ready, receives controls)
// Signals:
//   instr      [31:0] instruction register contents, valid from DECODE on
//   zero              ALU zero flag
//   mem_ready         memory completion strobe
//   alu_op     [2:0]  ALU operation
//   sign_op           ALU modifier (ADD: 0=sub 1=add, SRL: 1=arithmetic)
//   alu_src_a  [1:0]  00 PC, 01 old_pc, 10 rs1, 11 zero
//   alu_src_b  [1:0]  00 rs2, 01 imm, 10 const 4
//   imm_src    [2:0]  000 I, 001 S, 010 B, 011 J, 100 U
//   result_src [1:0]  00 alu_out reg, 01 mem data, 10 ALU result
//   adr_src           0 PC, 1 result
//   pc_write, ir_write, reg_write, mem_req, mem_we : strobes
//   halted            core stopped
//   state      [3:0]  current FSM state
// ---------------------------------------------------------------------------
interface control_unit_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic [2:0]  alu_op;
    logic        sign_op;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  imm_src;
    logic [1:0]  result_src;
    logic        adr_src;
    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic        mem_req;
    logic        mem_we;
    logic        halted;
    logic [3:0]  state;

    modport master (
        input  instr, zero, mem_ready,
        output alu_op, sign_op, alu_src_a, alu_src_b, imm_src, result_src,
               adr_src, pc_write, ir_write, reg_write, mem_req, mem_we,
               halted, state
    );

    modport slave (
        output instr, zero, mem_ready,
        input  alu_op, sign_op, alu_src_a, alu_src_b, imm_src, result_src,
               adr_src, pc_write, ir_write, reg_write, mem_req, mem_we,
               halted, state
    );
endinterface

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Moore-style multicycle control FSM for an RV32I subset core. Each state
// drives the datapath mux selects and strobes for one step of instruction
// execution; the decode step dispatches on the opcode.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     control_unit_if.master (instr/zero/mem_ready in, controls out)
// Notes:
//   Outputs are decoded from the state register plus the few inputs a state
//   qualifies on (mem_ready in FETCH, funct fields, zero in BRANCH). While
//   resetn is low every strobe and halted are forced low even though the
//   state register already reads FETCH, so memory is never requested during
//   reset.
// ---------------------------------------------------------------------------
module control_unit (
    input  logic               clk,
    input  logic               resetn,
    control_unit_if.master     bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_LUI      = 4'd11,
        S_AUIPC    = 4'd12,
        S_JALR     = 4'd13,
        S_HALT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t      state_r;
    state_t      next_state_s;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic        funct7_b5_s;
    logic        unused_instr_s;

    logic [2:0]  alu_op_s;
    logic        sign_op_s;
    logic [1:0]  alu_src_a_s;
    logic [1:0]  alu_src_b_s;
    logic [2:0]  imm_src_s;
    logic [1:0]  result_src_s;
    logic        adr_src_s;
    logic        pc_write_s;
    logic        ir_write_s;
    logic        reg_write_s;
    logic        mem_req_s;
    logic        mem_we_s;
    logic        halted_s;

    assign opcode_s    = bus.instr[6:0];
    assign funct3_s    = bus.instr[14:12];
    assign funct7_b5_s = bus.instr[30];

    // Register/immediate fields belong to the datapath, not to control.
    assign unused_instr_s = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // State register; reset lands in FETCH asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        next_state_s = state_r;
        alu_op_s     = 3'b000;
        sign_op_s    = 1'b1;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        imm_src_s    = 3'b000;
        result_src_s = 2'b00;
        adr_src_s    = 1'b0;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        halted_s     = 1'b0;

        case (state_r)
            S_FETCH: begin
                // PC+4 is computed alongside the fetch and committed with the IR.
                mem_req_s    = 1'b1;
                adr_src_s    = 1'b0;
                alu_src_a_s  = 2'b00;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                if (bus.mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end

            S_DECODE: begin
                // old_pc + imm precomputes the branch/jump target into alu_out.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                if (opcode_s == OP_JAL) begin
                    imm_src_s = 3'b011;
                end else begin
                    imm_src_s = 3'b010;
                end
                case (opcode_s)
                    OP_LOAD:   next_state_s = S_MEMADR;
                    OP_STORE:  next_state_s = S_MEMADR;
                    OP_RTYPE:  next_state_s = S_EXECR;
                    OP_ITYPE:  next_state_s = S_EXECI;
                    OP_BRANCH: next_state_s = S_BRANCH;
                    OP_JAL:    next_state_s = S_JAL;
                    OP_JALR:   next_state_s = S_JALR;
                    OP_LUI:    next_state_s = S_LUI;
                    OP_AUIPC:  next_state_s = S_AUIPC;
                    default:   next_state_s = S_HALT;
                endcase
            end

            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                if (opcode_s == OP_STORE) begin
                    imm_src_s    = 3'b001;
                    next_state_s = S_MEMWRITE;
                end else begin
                    imm_src_s    = 3'b000;
                    next_state_s = S_MEMREAD;
                end
            end

            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                if (bus.mem_ready) begin
                    next_state_s = S_MEMWB;
                end else begin
                    next_state_s = S_MEMREAD;
                end
            end

            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                next_state_s = S_FETCH;
            end

            S_MEMWRITE: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                adr_src_s = 1'b1;
                if (bus.mem_ready) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end

            S_EXECR: begin
                // funct7[5] selects sub (inverted: sign_op=1 means add) and sra.
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b00;
                alu_op_s    = funct3_s;
                case (funct3_s)
                    3'b000:  sign_op_s = ~funct7_b5_s;
                    3'b101:  sign_op_s = funct7_b5_s;
                    default: sign_op_s = 1'b0;
                endcase
                next_state_s = S_ALUWB;
            end

            S_EXECI: begin
                // addi has no subtract form, so only srai uses funct7[5].
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                imm_src_s   = 3'b000;
                alu_op_s    = funct3_s;
                case (funct3_s)
                    3'b000:  sign_op_s = 1'b1;
                    3'b101:  sign_op_s = funct7_b5_s;
                    default: sign_op_s = 1'b0;
                endcase
                next_state_s = S_ALUWB;
            end

            S_ALUWB: begin
                result_src_s = 2'b00;
                reg_write_s  = 1'b1;
                next_state_s = S_FETCH;
            end

            S_JALR: begin
                // rs1 + imm overwrites the DECODE target; JAL then commits it.
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                imm_src_s    = 3'b000;
                next_state_s = S_JAL;
            end

            S_JAL: begin
                // PC <- alu_out (target) while old_pc+4 becomes the link value.
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b00;
                pc_write_s   = 1'b1;
                next_state_s = S_ALUWB;
            end

            S_LUI: begin
                alu_src_a_s  = 2'b11;
                alu_src_b_s  = 2'b01;
                imm_src_s    = 3'b100;
                next_state_s = S_ALUWB;
            end

            S_AUIPC: begin
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b01;
                imm_src_s    = 3'b100;
                next_state_s = S_ALUWB;
            end

            S_BRANCH: begin
                // Compare via sub (eq/ne), slt (lt/ge) or sltu (ltu/geu); the
                // ALU zero flag then decides, inverted for ne/lt/ltu.
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b00;
                result_src_s = 2'b00;
                case (funct3_s)
                    3'b000, 3'b001: begin
                        alu_op_s  = 3'b000;
                        sign_op_s = 1'b0;
                    end
                    3'b100, 3'b101: begin
                        alu_op_s  = 3'b010;
                        sign_op_s = 1'b1;
                    end
                    3'b110, 3'b111: begin
                        alu_op_s  = 3'b011;
                        sign_op_s = 1'b1;
                    end
                    default: begin
                        alu_op_s  = 3'b000;
                        sign_op_s = 1'b1;
                    end
                endcase
                case (funct3_s)
                    3'b000, 3'b101, 3'b111: begin
                        pc_write_s   = bus.zero;
                        next_state_s = S_FETCH;
                    end
                    3'b001, 3'b100, 3'b110: begin
                        pc_write_s   = ~bus.zero;
                        next_state_s = S_FETCH;
                    end
                    default: begin
                        pc_write_s   = 1'b0;
                        next_state_s = S_HALT;
                    end
                endcase
            end

            S_HALT: begin
                halted_s     = 1'b1;
                next_state_s = S_HALT;
            end

            default: begin
                // Unencoded state value: stop the core rather than run on.
                next_state_s = S_HALT;
            end
        endcase
    end

    // Strobes and halted are qualified by resetn so they drop the instant
    // reset asserts, independent of the state decode.
    assign bus.pc_write   = pc_write_s  & resetn;
    assign bus.ir_write   = ir_write_s  & resetn;
    assign bus.reg_write  = reg_write_s & resetn;
    assign bus.mem_req    = mem_req_s   & resetn;
    assign bus.mem_we     = mem_we_s    & resetn;
    assign bus.halted     = halted_s    & resetn;

    assign bus.alu_op     = alu_op_s;
    assign bus.sign_op    = sign_op_s;
    assign bus.alu_src_a  = alu_src_a_s;
    assign bus.alu_src_b  = alu_src_b_s;
    assign bus.imm_src    = imm_src_s;
    assign bus.result_src = result_src_s;
    assign bus.adr_src    = adr_src_s;
    assign bus.state      = state_r;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; resetn  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: instr  in  32  instruction-register contents, valid from DECODE onward; zero  in  1  ALU zero flag; mem_ready  in  1  memory completion strobe.
REQ-003 SHALL have outputs: alu_op  out  3  ALU operation; sign_op  out  1  ALU modifier (ADD: 0=sub, 1=add; SRL: 1=arithmetic).
REQ-004 SHALL have outputs: alu_src_a  out  2  (00 PC, 01 old_pc, 10 rs1, 11 zero); alu_src_b  out  2  (00 rs2, 01 imm, 10 const 4); imm_src  out  3  (000 I, 001 S, 010 B, 011 J, 100 U).
REQ-005 SHALL have outputs: result_src  out  2  (00 alu_out reg, 01 mem data, 10 ALU result); adr_src  out  1  (0 PC, 1 result).
REQ-006 SHALL have outputs: pc_write, ir_write, reg_write, mem_req, mem_we  out  1 each  strobes; halted  out  1  core stopped; state  out  4  current state.
REQ-007 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-008 SHALL implement a Moore FSM. States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BRANCH=10, LUI=11, AUIPC=12, JALR=13, HALT=15.
REQ-009 Unlisted outputs SHALL be 0; by default alu_op=000 and sign_op=1 (add).
REQ-010 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10; when mem_ready=1, ir_write=1 and pc_write=1, go to DECODE; else stay.
REQ-011 DECODE: alu_src_a=01, alu_src_b=01, imm_src=011 if opcode 1101111 else 010; next by opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111->LUI, 0010111->AUIPC, other (incl. 1110011)->HALT.
REQ-012 MEMADR: alu_src_a=10, alu_src_b=01, imm_src=000 for load, 001 for store; next MEMREAD (load) or MEMWRITE (store).
REQ-013 MEMREAD: mem_req=1, adr_src=1; wait for mem_ready=1, then MEMWB. MEMWB: result_src=01, reg_write=1, then FETCH.
REQ-014 MEMWRITE: mem_req=1, mem_we=1, adr_src=1; wait for mem_ready=1, then FETCH.
REQ-015 EXECR: alu_src_a=10, alu_src_b=00, alu_op=funct3; sign_op=~funct7[5] when funct3=000, funct7[5] when funct3=101, else 0; then ALUWB.
REQ-016 EXECI: alu_src_a=10, alu_src_b=01, imm_src=000, alu_op=funct3; sign_op=1 when funct3=000, funct7[5] when funct3=101, else 0; then ALUWB.
REQ-017 ALUWB: result_src=00, reg_write=1, then FETCH.
REQ-018 JALR: alu_src_a=10, alu_src_b=01, imm_src=000; then JAL. Target bit 0 is not cleared by this block.
REQ-019 JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1; then ALUWB.
REQ-020 LUI: alu_src_a=11, alu_src_b=01, imm_src=100; AUIPC: the same with alu_src_a=01; both then ALUWB.
REQ-021 BRANCH: alu_src_a=10, alu_src_b=00, result_src=00; funct3 000/001: alu_op=000, sign_op=0; 100/101: alu_op=010; 110/111: alu_op=011.
REQ-022 BRANCH taken condition: funct3 000, 101, 111 -> zero=1; 001, 100, 110 -> zero=0. pc_write=taken. Next FETCH; funct3 010/011 SHALL go to HALT with pc_write=0.
REQ-023 HALT: halted=1, all strobes 0; remain until reset.
REQ-024 mem_ready SHALL be ignored outside FETCH, MEMREAD and MEMWRITE.
REQ-025 Latency: ALU/LUI/AUIPC 4 cycles; load 5+wait; store 4+wait; branch 3; JAL 4; JALR 5 (zero-wait memory).

Reset
REQ-026 resetn=0 SHALL immediately force state=FETCH and drive pc_write, ir_write, reg_write, mem_req, mem_we and halted to 0 while low, including mid-instruction and while waiting on memory.
REQ-027 The first rising clk edge after resetn rises SHALL evaluate FETCH normally.

Verification
REQ-028 addi x1,x0,5 (0x00500093), mem_ready=1 in FETCH -> states 0,1,7,8,0; EXECI alu_op=000, sign_op=1; reg_write=1 only in ALUWB.
REQ-029 sub (funct7=0100000, funct3=000) -> EXECR sign_op=0; sra (funct3=101, funct7[5]=1) -> alu_op=101, sign_op=1; srli -> sign_op=0.
REQ-030 lw with mem_ready held low 3 cycles in MEMREAD -> stays in state 3 for 3 cycles with mem_req=1, adr_src=1, then MEMWB with result_src=01.
REQ-031 bne, zero=0 -> BRANCH pc_write=1; zero=1 -> pc_write=0; bgeu, zero=1 -> alu_op=011, pc_write=1.
REQ-032 jalr -> states 0,1,13,9,8,0; pc_write in JAL; reg_write in ALUWB.
REQ-033 ecall (0x00000073) -> HALT with halted=1 for 20 cycles; resetn pulse low mid-MEMWRITE -> state=0 and mem_we=0 asynchronously.
